// File: rtl/robot_pkg.sv
// Shared encodings for the pipe-cleaning robot navigator: FSM states,
// orientation codes, action selector and the right-turn helper.
package robot_pkg;

   typedef enum logic [2:0] {
      ST_SEARCH        = 3'b000,
      ST_ROTATE        = 3'b001,
      ST_REMOVE_FOLLOW = 3'b010,
      ST_STANDBY       = 3'b011,
      ST_FIRST_MOVE    = 3'b100,
      ST_RESETTING     = 3'b101
   } state_e;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_FRONT,
      ACT_TURN,
      ACT_REMOVE
   } action_e;

   localparam logic [3:0] OR_NORTH = 4'b0000;
   localparam logic [3:0] OR_SOUTH = 4'b0001;
   localparam logic [3:0] OR_EAST  = 4'b0010;
   localparam logic [3:0] OR_WEST  = 4'b0011;

   // Clockwise 90 degrees: N -> E -> S -> W -> N.
   function automatic logic [3:0] turn_right(input logic [3:0] orient);
      case (orient)
         OR_NORTH: turn_right = OR_EAST;
         OR_EAST:  turn_right = OR_SOUTH;
         OR_SOUTH: turn_right = OR_WEST;
         default:  turn_right = OR_NORTH;
      endcase
   endfunction

endpackage

// File: rtl/robot_pose.sv
// Robot pose (row/column/orientation) with move/turn application and a
// look-ahead bounds check for the cell directly in front of the robot.
module robot_pose
   import robot_pkg::*;
#(
   parameter int         ROWS         = 10,
   parameter int         COLS         = 20,
   parameter int         START_ROW    = 1,
   parameter int         START_COL    = 1,
   parameter logic [3:0] START_ORIENT = OR_EAST
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_move,
   input  logic       i_turn,
   output logic [5:0] o_row,
   output logic [5:0] o_col,
   output logic [3:0] o_orient,
   output logic       o_out_of_map
);

   logic [5:0] r_row;
   logic [5:0] r_col;
   logic [3:0] r_orient;
   logic [6:0] w_tgt_row;
   logic [6:0] w_tgt_col;

   // Targets are one bit wider so row 63 + 1 cannot wrap back into the map.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_tgt_row = {1'b0, r_row};
      w_tgt_col = {1'b0, r_col};
      case (r_orient)
         OR_NORTH: w_tgt_row = {1'b0, r_row} - 7'd1;
         OR_SOUTH: w_tgt_row = {1'b0, r_row} + 7'd1;
         OR_EAST:  w_tgt_col = {1'b0, r_col} + 7'd1;
         OR_WEST:  w_tgt_col = {1'b0, r_col} - 7'd1;
         default:  ;
      endcase
   end

   assign o_out_of_map = (w_tgt_row == 7'd0) || (w_tgt_row > 7'(ROWS)) ||
                         (w_tgt_col == 7'd0) || (w_tgt_col > 7'(COLS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row    <= 6'(START_ROW);
         r_col    <= 6'(START_COL);
         r_orient <= START_ORIENT;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         if (i_move) begin
            r_row <= w_tgt_row[5:0];
            r_col <= w_tgt_col[5:0];
         end
         if (i_turn) r_orient <= turn_right(r_orient);
      end
   end

   assign o_row    = r_row;
   assign o_col    = r_col;
   assign o_orient = r_orient;

endmodule

// File: rtl/robot_nav_ctrl.sv
// Left-wall-following navigator with trash removal, map guard and optional
// stuck detection (compiled in when ROBOT_NAV_STUCK_DET_EN is defined).
module robot_nav_ctrl
   import robot_pkg::*;
#(
   parameter int         ROWS         = 10,
   parameter int         COLS         = 20,
   parameter int         START_ROW    = 1,
   parameter int         START_COL    = 1,
   parameter logic [3:0] START_ORIENT = OR_EAST,
   parameter int         REMOVE_STEPS = 3,
   parameter int         STUCK_LIMIT  = 16
) (
   input  logic       clock_50,
   input  logic       reset_key,
   input  logic       step_en,
   input  logic       mode,
   input  logic       head,
   input  logic       left,
   input  logic       barrier,
   output logic       front,
   output logic       turn,
   output logic       remove,
   output logic [5:0] robot_row,
   output logic [5:0] robot_column,
   output logic [3:0] robot_orientation,
   output logic [2:0] act_state,
   output logic       anomaly,
   output logic       stuck
);

   state_e     r_state,    w_state_nxt;
   action_e    r_act,      w_act;
   logic [1:0] r_rot_cnt,  w_rot_nxt;
   logic [3:0] r_rem_cnt,  w_rem_nxt;
   logic       r_removing, w_removing_nxt;
   logic       r_anomaly,  w_anomaly_nxt;
   logic       w_stuck_flag;
   logic       w_out_of_map;

`ifdef ROBOT_NAV_STUCK_DET_EN
   logic [7:0] r_stuck_cnt, w_stuck_cnt_nxt;
   logic       r_stuck,     w_stuck_nxt;
   logic       w_counts;
   assign w_stuck_flag = r_stuck;
`else
   assign w_stuck_flag = 1'b0;
`endif

   robot_pose #(
      .ROWS(ROWS), .COLS(COLS), .START_ROW(START_ROW),
      .START_COL(START_COL), .START_ORIENT(START_ORIENT)
   ) u_pose (
      .clk          (clock_50),
      .rst_n        (reset_key),
      .i_move       (w_act == ACT_FRONT),
      .i_turn       (w_act == ACT_TURN),
      .o_row        (robot_row),
      .o_col        (robot_column),
      .o_orient     (robot_orientation),
      .o_out_of_map (w_out_of_map)
   );

   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) begin
         r_state     <= ST_RESETTING;
         r_act       <= ACT_NONE;
         r_rot_cnt   <= '0;
         r_rem_cnt   <= '0;
         r_removing  <= 1'b0;
         r_anomaly   <= 1'b0;
`ifdef ROBOT_NAV_STUCK_DET_EN
         r_stuck_cnt <= '0;
         r_stuck     <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_act       <= w_act;
         r_rot_cnt   <= w_rot_nxt;
         r_rem_cnt   <= w_rem_nxt;
         r_removing  <= w_removing_nxt;
         r_anomaly   <= w_anomaly_nxt;
`ifdef ROBOT_NAV_STUCK_DET_EN
         r_stuck_cnt <= w_stuck_cnt_nxt;
         r_stuck     <= w_stuck_nxt;
`endif
      end
   end

`ifdef ROBOT_NAV_STUCK_DET_EN
   // Removal steps and idle/standby steps do not age the stuck counter.
   assign w_counts = step_en && mode &&
                     ((r_state == ST_SEARCH && !barrier) || r_state == ST_ROTATE ||
                      r_state == ST_FIRST_MOVE || (r_state == ST_REMOVE_FOLLOW && !r_removing));
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_act          = ACT_NONE;
      w_rot_nxt      = r_rot_cnt;
      w_rem_nxt      = r_rem_cnt;
      w_removing_nxt = r_removing;
      w_anomaly_nxt  = r_anomaly;
`ifdef ROBOT_NAV_STUCK_DET_EN
      w_stuck_cnt_nxt = r_stuck_cnt;
      w_stuck_nxt     = r_stuck;
`endif
      if (step_en) begin
         if (!mode) begin
            w_state_nxt = ST_STANDBY;
         end else begin
            case (r_state)
               ST_RESETTING:  w_state_nxt = ST_FIRST_MOVE;
               ST_FIRST_MOVE: begin
                  w_act       = head ? ACT_TURN : ACT_FRONT;
                  w_state_nxt = ST_SEARCH;
               end
               ST_SEARCH: begin
                  if (barrier) begin
                     w_act          = ACT_REMOVE;
                     w_state_nxt    = ST_REMOVE_FOLLOW;
                     w_removing_nxt = 1'b1;
                     w_rem_nxt      = 4'(REMOVE_STEPS - 1);
                  end else if (!left) begin
                     w_act       = ACT_TURN;
                     w_state_nxt = ST_ROTATE;
                     w_rot_nxt   = 2'd2;
                  end else begin
                     w_act = head ? ACT_TURN : ACT_FRONT;
                  end
               end
               ST_ROTATE: begin
                  if (r_rot_cnt != 2'd0) begin
                     w_act     = ACT_TURN;
                     w_rot_nxt = r_rot_cnt - 2'd1;
                  end else begin
                     w_state_nxt    = ST_REMOVE_FOLLOW;
                     w_removing_nxt = 1'b0;
                  end
               end
               ST_REMOVE_FOLLOW: begin
                  if (r_removing) begin
                     if (r_rem_cnt != 4'd0) begin
                        w_act     = ACT_REMOVE;
                        w_rem_nxt = r_rem_cnt - 4'd1;
                     end else begin
                        w_state_nxt    = ST_SEARCH;
                        w_removing_nxt = 1'b0;
                     end
                  end else begin
                     w_act       = head ? ACT_TURN : ACT_FRONT;
                     w_state_nxt = ST_SEARCH;
                  end
               end
               ST_STANDBY: if (!r_anomaly && !w_stuck_flag) w_state_nxt = ST_SEARCH;
               default:    w_state_nxt = ST_RESETTING;
            endcase

            if (w_act == ACT_FRONT && w_out_of_map) begin
               w_act         = ACT_NONE;
               w_anomaly_nxt = 1'b1;
               w_state_nxt   = ST_STANDBY;
            end
         end
      end
`ifdef ROBOT_NAV_STUCK_DET_EN
      if (w_counts) begin
         if (w_act == ACT_FRONT)         w_stuck_cnt_nxt = 8'd0;
         else if (r_stuck_cnt != 8'hFF)  w_stuck_cnt_nxt = r_stuck_cnt + 8'd1;
         if (w_stuck_cnt_nxt >= 8'(STUCK_LIMIT)) begin
            w_stuck_nxt = 1'b1;
            w_state_nxt = ST_STANDBY;
         end
      end
`endif
   end

   always_comb begin
      front     = (r_act == ACT_FRONT);
      turn      = (r_act == ACT_TURN);
      remove    = (r_act == ACT_REMOVE);
      act_state = r_state;
      anomaly   = r_anomaly;
      stuck     = w_stuck_flag;
   end

endmodule
